bootprom_reader: RTL

Bus-side sequencer that reads the boot EPROM pair: a high-byte and a low-byte 27256 sharing one address bus. It drives address, CE_n and OE_n, waits a programmable access time, and samples both byte lanes into a 16-bit word. Each word is emitted on a valid/ready stream, so boot code can be copied to RAM or checksummed before the 68010 core is released from reset.

---
 rtl/bootprom_reader_if.sv | 28 ++
 rtl/bootprom_reader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bootprom_reader_if.sv
// Bundle of the command, EPROM bus and word-stream signals of the boot EPROM reader.
// master = the sequencer, slave = the surrounding system (command source, EPROMs, consumer).
interface bootprom_reader_if;
    logic        start;
    logic [14:0] start_addr;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [14:0] rom_addr;
    logic        rom_ce_n;
    logic        rom_oe_n;
    logic [7:0]  rom_data_h;
    logic [7:0]  rom_data_l;
    logic [15:0] word_data;
    logic [14:0] word_addr;
    logic        word_valid;
    logic        word_ready;

    modport master (
        input  start, start_addr, count, rom_data_h, rom_data_l, word_ready,
        output busy, done, rom_addr, rom_ce_n, rom_oe_n, word_data, word_addr, word_valid
    );

    modport slave (
        output start, start_addr, count, rom_data_h, rom_data_l, word_ready,
        input  busy, done, rom_addr, rom_ce_n, rom_oe_n, word_data, word_addr, word_valid
    );
endinterface

// File: rtl/bootprom_reader.sv
// Sequencer reading a high/low 27256 EPROM pair word by word and emitting
// each 16-bit word with its address on a valid/ready stream.
module bootprom_reader #(
    parameter int ACCESS_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    bootprom_reader_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_OUT    = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [14:0] r_addr;
    logic [16:0] r_remaining;
    logic [3:0]  r_wait;
    logic [15:0] r_word_data;
    logic [14:0] r_word_addr;
    logic        r_word_valid;

    logic        w_start_go;
    logic        w_start_empty;
    logic        w_access_last;
    logic        w_xfer;
    logic        w_last_word;

    assign w_start_go    = (r_state == ST_IDLE) && bus.start && (bus.count != 16'd0);
    assign w_start_empty = (r_state == ST_IDLE) && bus.start && (bus.count == 16'd0);
    assign w_access_last = (r_state == ST_ACCESS) && (r_wait == 4'(ACCESS_CYCLES - 1));
    assign w_xfer        = (r_state == ST_OUT) && r_word_valid && bus.word_ready;
    assign w_last_word   = (r_remaining <= 17'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_go) begin
                    w_state_next = ST_SETUP;
                end else if (w_start_empty) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_SETUP:  w_state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (w_access_last) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (w_xfer) begin
                    w_state_next = w_last_word ? ST_FIN : ST_SETUP;
                end
            end
            ST_FIN:    w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // OE_n only ever falls in ACCESS, where CE_n is already low
    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.rom_ce_n = 1'b1;
        bus.rom_oe_n = 1'b1;
        case (r_state)
            ST_SETUP: begin
                bus.busy     = 1'b1;
                bus.rom_ce_n = 1'b0;
            end
            ST_ACCESS: begin
                bus.busy     = 1'b1;
                bus.rom_ce_n = 1'b0;
                bus.rom_oe_n = 1'b0;
            end
            ST_OUT: begin
                bus.busy = 1'b1;
            end
            ST_FIN: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The address only advances when another word follows, so rom_addr keeps
    // showing the last location read once the command has finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= 15'd0;
            r_remaining  <= 17'd0;
            r_wait       <= 4'd0;
            r_word_data  <= 16'd0;
            r_word_addr  <= 15'd0;
            r_word_valid <= 1'b0;
        end else begin
            if (w_start_go) begin
                r_addr      <= bus.start_addr;
                r_remaining <= {1'b0, bus.count};
            end
            if (r_state == ST_SETUP) begin
                r_wait <= 4'd0;
            end else if (r_state == ST_ACCESS) begin
                r_wait <= r_wait + 4'd1;
            end
            if (w_access_last) begin
                r_word_data  <= {bus.rom_data_h, bus.rom_data_l};
                r_word_addr  <= r_addr;
                r_word_valid <= 1'b1;
            end
            if (w_xfer) begin
                r_word_valid <= 1'b0;
                r_remaining  <= r_remaining - 17'd1;
                if (!w_last_word) begin
                    r_addr <= r_addr + 15'd1;
                end
            end
        end
    end

    assign bus.rom_addr   = r_addr;
    assign bus.word_data  = r_word_data;
    assign bus.word_addr  = r_word_addr;
    assign bus.word_valid = r_word_valid;

endmodule
